fir_coeff_loader: RTL and testbench

Upstream configuration stage for the FIR datapath: accepts coefficient bytes over a valid/ready byte stream and assembles them in a shadow bank. It commits the bank atomically onto the packed coefficient bus that drives the FIR filter. The filter therefore never sees a partially written set. It replaces the hard-wired coefficient constants and powers up with the same default taps.

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_coeff_loader.sv | 143 ++++++++++++++
 tb/tb_fir_coeff_loader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient path: loader FSM states,
// default tap values and index-width helper.
package fir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_CHECK  = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   localparam int DEFAULT_NUM_COEFF = 4;

   // Power-up tap k is k+1, matching the constants the FIR used to hard-wire.
   function automatic int default_tap(input int k);
      return k + 1;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEFAULT_IDX_W = idx_width(DEFAULT_NUM_COEFF);

endpackage

// File: rtl/fir_coeff_loader.sv
// Byte-stream coefficient loader with shadow bank and atomic commit.
// Optional trailing checksum byte enabled by FIR_COEFF_CHECKSUM_EN.
module fir_coeff_loader
   import fir_pkg::*;
#(
   parameter int NUM_COEFF = 4,
   parameter int SIZE      = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_start,
   input  logic                      cfg_valid,
   input  logic [SIZE-1:0]           cfg_data,
   output logic                      cfg_ready,
   output logic [NUM_COEFF*SIZE-1:0] coeffs,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   localparam int IW = idx_width(NUM_COEFF);

   state_t                    state_reg;
   logic [IW-1:0]             idx_reg;
   logic [SIZE-1:0]           shadow_reg [NUM_COEFF];
   logic [NUM_COEFF*SIZE-1:0] shadow_flat;
   logic [NUM_COEFF*SIZE-1:0] coeffs_reg;
   logic                      cfg_ready_reg;
   logic                      busy_reg;
   logic                      done_reg;
   logic                      accept;
   logic                      last_byte;
`ifdef FIR_COEFF_CHECKSUM_EN
   logic [SIZE-1:0]           sum_reg;
   logic                      err_reg;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_COEFF; gi++) begin : g_pack
         assign shadow_flat[gi*SIZE +: SIZE] = shadow_reg[gi];
      end
   endgenerate

   assign accept    = cfg_valid & cfg_ready_reg;
   assign last_byte = (idx_reg == IW'(NUM_COEFF - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         idx_reg       <= '0;
         cfg_ready_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         for (int k = 0; k < NUM_COEFF; k++) begin
            shadow_reg[k]                <= '0;
            coeffs_reg[k*SIZE +: SIZE]   <= SIZE'(default_tap(k));
         end
`ifdef FIR_COEFF_CHECKSUM_EN
         sum_reg       <= '0;
         err_reg       <= 1'b0;
`endif
      end else begin
         done_reg <= 1'b0;
`ifdef FIR_COEFF_CHECKSUM_EN
         err_reg  <= 1'b0;
`endif
         // Restart wins over data and over a pending commit.
         if (cfg_start) begin
            state_reg     <= ST_LOAD;
            idx_reg       <= '0;
            cfg_ready_reg <= 1'b1;
            busy_reg      <= 1'b1;
`ifdef FIR_COEFF_CHECKSUM_EN
            sum_reg       <= '0;
`endif
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  cfg_ready_reg <= 1'b0;
                  busy_reg      <= 1'b0;
               end
               ST_LOAD: begin
                  if (accept) begin
                     shadow_reg[idx_reg] <= cfg_data;
`ifdef FIR_COEFF_CHECKSUM_EN
                     sum_reg <= sum_reg + cfg_data;
`endif
                     if (last_byte) begin
                        idx_reg <= '0;
`ifdef FIR_COEFF_CHECKSUM_EN
                        state_reg <= ST_CHECK;
`else
                        state_reg     <= ST_COMMIT;
                        cfg_ready_reg <= 1'b0;
`endif
                     end else begin
                        idx_reg <= idx_reg + 1'b1;
                     end
                  end
               end
`ifdef FIR_COEFF_CHECKSUM_EN
               ST_CHECK: begin
                  if (accept) begin
                     cfg_ready_reg <= 1'b0;
                     if (cfg_data == sum_reg) begin
                        state_reg <= ST_COMMIT;
                     end else begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        err_reg   <= 1'b1;
                     end
                  end
               end
`endif
               ST_COMMIT: begin
                  coeffs_reg    <= shadow_flat;
                  done_reg      <= 1'b1;
                  state_reg     <= ST_IDLE;
                  busy_reg      <= 1'b0;
                  cfg_ready_reg <= 1'b0;
               end
               default: begin
                  state_reg     <= ST_IDLE;
                  cfg_ready_reg <= 1'b0;
                  busy_reg      <= 1'b0;
               end
            endcase
         end
      end
   end

   assign cfg_ready = cfg_ready_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign coeffs    = coeffs_reg;
`ifdef FIR_COEFF_CHECKSUM_EN
   assign err       = err_reg;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: vector table plus corner-case
// sequences; committed values are checked through a scoreboard queue.
module tb_fir_coeff_loader;

   localparam int N = 4;
   localparam logic [31:0] DEF = 32'h04030201;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_start = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [7:0]  cfg_data = 8'h00;
   logic        cfg_ready;
   logic [31:0] coeffs;
   logic        busy;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   fir_coeff_loader #(.NUM_COEFF(N), .SIZE(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready),
      .coeffs    (coeffs),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   typedef struct {
      logic [3:0][7:0] b;     // b[0] is sent first
      int              gap;
      logic [31:0]     exp;
   } vec_t;

   int          total = 0;
   int          bad = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          commits = 0;
   int          errs_exp = 0;
   logic [31:0] model = DEF;
   logic [31:0] exp_q[$];
   vec_t        vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [31:0] e;
      if (rst_n && done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("commit_coeffs", coeffs, e);
         end
      end
      if (rst_n && err) err_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Start pulse with a junk byte alongside it; that byte must be dropped.
   task automatic do_start();
      cfg_start = 1'b1;
      cfg_valid = 1'b1;
      cfg_data  = 8'hEE;
      @(negedge clk);
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      int w;
      cfg_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         cfg_data = 8'($urandom);
         @(negedge clk);
      end
      cfg_valid = 1'b1;
      cfg_data  = b;
      w = 0;
      while (!cfg_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!cfg_ready) check("ready_timeout", {31'd0, cfg_ready}, 32'd1);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   function automatic int pick_gap(input int maxgap);
      return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
   endfunction

   // mode 0: commit expected, 1: bad checksum, 2: stop while in COMMIT
   task automatic load(input logic [3:0][7:0] b, input int maxgap, input int mode,
                       input logic [31:0] exp);
      logic [7:0] ck;
      ck = b[0] + b[1] + b[2] + b[3];
      if (mode == 1) ck = ck + 8'd1;
      do_start();
      check("busy_after_start", {31'd0, busy}, 32'd1);
      check("ready_after_start", {31'd0, cfg_ready}, 32'd1);
      for (int i = 0; i < N; i++) begin
`ifndef FIR_COEFF_CHECKSUM_EN
         if (i == N - 1 && mode == 0) exp_q.push_back(exp);
`endif
         send(b[i], pick_gap(maxgap));
      end
`ifdef FIR_COEFF_CHECKSUM_EN
      if (mode == 0) exp_q.push_back(exp);
      send(ck, pick_gap(maxgap));
`endif
      $display("load mode=%0d bytes=%02h,%02h,%02h,%02h ck=%02h exp=0x%08h",
               mode, b[0], b[1], b[2], b[3], ck, exp);
      if (mode == 0) begin
         check("done_early", {31'd0, done}, 32'd0);
         check("coeffs_before_commit", coeffs, model);
         @(negedge clk);
         check("done_pulse", {31'd0, done}, 32'd1);
         model = exp;
         commits++;
         @(negedge clk);
         check("done_one_cycle", {31'd0, done}, 32'd0);
         check("idle_after_commit", {30'd0, busy, cfg_ready}, 32'd0);
      end else if (mode == 1) begin
         check("err_pulse", {31'd0, err}, 32'd1);
         check("ready_after_err", {31'd0, cfg_ready}, 32'd0);
         check("busy_after_err", {31'd0, busy}, 32'd0);
         check("coeffs_kept_on_err", coeffs, model);
         @(negedge clk);
         check("err_one_cycle", {31'd0, err}, 32'd0);
         errs_exp++;
      end
   endtask

   initial begin
      vecs[0] = '{b: {8'h40, 8'h30, 8'h20, 8'h10}, gap: 0, exp: 32'h40302010};
      vecs[1] = '{b: {8'h04, 8'h03, 8'h02, 8'h01}, gap: 1, exp: 32'h04030201};
      vecs[2] = '{b: {8'h7F, 8'h80, 8'h00, 8'hFF}, gap: 2, exp: 32'h7F8000FF};
      vecs[3] = '{b: {8'h5A, 8'hA5, 8'hC3, 8'h3C}, gap: 3, exp: 32'h5AA5C33C};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_coeffs", coeffs, DEF);
      check("reset_flags", {28'd0, cfg_ready, busy, done, err}, 32'd0);

      // Valid data in IDLE without a start is ignored.
      cfg_valid = 1'b1;
      cfg_data  = 8'h99;
      repeat (3) @(negedge clk);
      check("idle_ready", {31'd0, cfg_ready}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_coeffs", coeffs, DEF);
      cfg_valid = 1'b0;

      for (int v = 0; v < 4; v++) load(vecs[v].b, vecs[v].gap, 0, vecs[v].exp);

`ifdef FIR_COEFF_CHECKSUM_EN
      load({8'h04, 8'h03, 8'h02, 8'h01}, 0, 1, 32'h0);
`endif

      // Restart after two bytes, then full load with random gaps.
      do_start();
      send(8'h55, 0);
      send(8'h66, 1);
      load({8'hDD, 8'hCC, 8'hBB, 8'hAA}, 3, 0, 32'hDDCCBBAA);

      // Restart while in COMMIT: no copy, no done; the next set lands instead.
      load({8'h44, 8'h33, 8'h22, 8'h11}, 0, 2, 32'h0);
      load({8'h99, 8'h88, 8'h77, 8'h66}, 1, 0, 32'h99887766);

      // Asynchronous reset mid-load restores defaults at once.
      do_start();
      send(8'h01, 0);
      send(8'h02, 0);
      rst_n = 1'b0;
      #1;
      check("async_reset_coeffs", coeffs, DEF);
      check("async_reset_busy", {30'd0, busy, cfg_ready}, 32'd0);
      model = DEF;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_reset_idle", {30'd0, busy, cfg_ready}, 32'd0);
      check("post_reset_coeffs", coeffs, DEF);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      check("done_count", done_cnt, commits);
      check("err_count", err_cnt, errs_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
